// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one memory port shared by instruction fetch and load/store, with fetch starvation relief.
// Optional macro ARB_TIMEOUT_EN aborts a transaction after TIMEOUT cycles without mem_ack and raises sticky err.
module mem_port_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic              err
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY_IF = 2'd1, BUSY_D = 2'd2} state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t            state_r;
  state_t            state_nxt_s;
  logic [3:0]        starve_cnt_r;
  logic [3:0]        starve_cnt_nxt_s;
  logic              grant_if_s;
  logic              grant_d_s;
  logic              finish_s;
  logic              timeout_hit_s;
  logic [DATA_W-1:0] finish_data_s;

  // Arbitration and next-state; fetch wins a tie only once it has lost STARVE_LIMIT times in a row
  always_comb begin
    state_nxt_s      = state_r;
    starve_cnt_nxt_s = starve_cnt_r;
    grant_if_s       = 1'b0;
    grant_d_s        = 1'b0;
    finish_s         = 1'b0;
    case (state_r)
      IDLE: begin
        if (if_req && (!d_req || (starve_cnt_r >= STARVE_MAX))) begin
          grant_if_s       = 1'b1;
          state_nxt_s      = BUSY_IF;
          starve_cnt_nxt_s = 4'd0;
        end else if (d_req) begin
          grant_d_s   = 1'b1;
          state_nxt_s = BUSY_D;
          if (if_req) begin
            starve_cnt_nxt_s = starve_cnt_r + 4'd1;
          end else begin
            starve_cnt_nxt_s = starve_cnt_r;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY_IF, BUSY_D: begin
        if (mem_ack || timeout_hit_s) begin
          finish_s    = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // An aborted transaction returns zero data
  assign finish_data_s = mem_ack ? mem_rdata : {DATA_W{1'b0}};

  // State, starvation counter, latched memory request and returned data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      starve_cnt_r <= 4'd0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= {ADDR_W{1'b0}};
      mem_wdata    <= {DATA_W{1'b0}};
      if_done      <= 1'b0;
      d_done       <= 1'b0;
      if_rdata     <= {DATA_W{1'b0}};
      d_rdata      <= {DATA_W{1'b0}};
    end else begin
      state_r      <= state_nxt_s;
      starve_cnt_r <= starve_cnt_nxt_s;
      if_done      <= 1'b0;
      d_done       <= 1'b0;
      if (grant_if_s) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= {DATA_W{1'b0}};
      end else if (grant_d_s) begin
        mem_req   <= 1'b1;
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
      end else if (finish_s) begin
        mem_req <= 1'b0;
        if (state_r == BUSY_IF) begin
          if_done  <= 1'b1;
          if_rdata <= finish_data_s;
        end else begin
          d_done   <= 1'b1;
          d_rdata  <= finish_data_s;
        end
      end
    end
  end

  assign stall = (if_req & ~if_done) | (d_req & ~d_done);

`ifdef ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] to_cnt_r;

  // Abort on the edge that would bring the busy-cycle count up to TIMEOUT
  assign timeout_hit_s = (state_r != IDLE) && !mem_ack && (to_cnt_r == TO_W'(TIMEOUT - 1));

  // Busy-cycle counter and sticky error flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt_r <= {TO_W{1'b0}};
      err      <= 1'b0;
    end else begin
      if (grant_if_s || grant_d_s) begin
        to_cnt_r <= {TO_W{1'b0}};
      end else if ((state_r != IDLE) && !mem_ack) begin
        to_cnt_r <= to_cnt_r + TO_W'(1);
      end
      if (timeout_hit_s) begin
        err <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit_s = 1'b0;
  // Always false; keeps TIMEOUT referenced in builds without the timeout logic
  assign err           = (TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, directed multi-cycle sequences and
// a randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int AW  = 64;
  localparam int DW  = 64;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, d_req, d_we, mem_ack;
  logic [AW-1:0] if_addr, d_addr;
  logic [DW-1:0] d_wdata, mem_rdata;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          if_done, d_done, mem_req, mem_we, stall, err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall), .err(err)
  );

  typedef struct {
    logic ir; logic [63:0] ia;
    logic dr; logic dw; logic [63:0] da; logic [63:0] dwd;
    logic ack; logic [63:0] rd;
    logic e_stall; logic e_req; logic e_we; logic [63:0] e_addr; logic [63:0] e_wdata;
    logic e_ifd; logic e_dd; logic [63:0] e_ifr; logic [63:0] e_dr;
  } vec_t;

  vec_t tv[13];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_order[10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};

  // reference model state (transaction level)
  int            owner, losses, wait_cnt;
  logic          m_req, m_we, m_ifd, m_dd;
  logic [63:0]   m_addr, m_wdata, m_ifr, m_dr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = 64'h0; d_req = 1'b0; d_we = 1'b0;
    d_addr = 64'h0; d_wdata = 64'h0; mem_ack = 1'b0; mem_rdata = 64'h0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".ctl"}, {59'h0, mem_req, mem_we, if_done, d_done, err}, 64'h0);
    check({tag, ".mem_addr"}, mem_addr, 64'h0);
    check({tag, ".mem_wdata"}, mem_wdata, 64'h0);
    check({tag, ".if_rdata"}, if_rdata, 64'h0);
    check({tag, ".d_rdata"}, d_rdata, 64'h0);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    int   grants[$];
    int   hi;
    int   stall_low;
    logic prev_req;
    logic pick_if;
    logic stall_exp;

    tv[0]  = '{1'b1, 64'h40, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 64'h0,
               1'b1, 1'b1, 1'b0, 64'h40, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0};
    tv[1]  = '{1'b1, 64'h40, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 64'h00500093,
               1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 1'b0, 64'h00500093, 64'h0};
    tv[2]  = '{1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 64'h0,
               1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h00500093, 64'h0};
    tv[3]  = '{1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 64'hFFFF,
               1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h00500093, 64'h0};
    tv[4]  = '{1'b0, 64'h0, 1'b1, 1'b1, 64'h10, 64'hDEADBEEF, 1'b0, 64'h0,
               1'b1, 1'b1, 1'b1, 64'h10, 64'hDEADBEEF, 1'b0, 1'b0, 64'h00500093, 64'h0};
    tv[5]  = tv[4];
    tv[6]  = '{1'b0, 64'h0, 1'b1, 1'b1, 64'h10, 64'hDEADBEEF, 1'b1, 64'hCAFE,
               1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 64'h00500093, 64'hCAFE};
    tv[7]  = '{1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 64'h0,
               1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h00500093, 64'hCAFE};
    tv[8]  = '{1'b1, 64'h80, 1'b1, 1'b0, 64'h20, 64'h0, 1'b0, 64'h0,
               1'b1, 1'b1, 1'b0, 64'h20, 64'h0, 1'b0, 1'b0, 64'h00500093, 64'hCAFE};
    tv[9]  = '{1'b1, 64'h80, 1'b1, 1'b0, 64'h20, 64'h0, 1'b1, 64'h77,
               1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 64'h00500093, 64'h77};
    tv[10] = '{1'b1, 64'h80, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 64'h0,
               1'b1, 1'b1, 1'b0, 64'h80, 64'h0, 1'b0, 1'b0, 64'h00500093, 64'h77};
    tv[11] = '{1'b1, 64'h80, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 64'h99,
               1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 1'b0, 64'h99, 64'h77};
    tv[12] = '{1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 64'h0,
               1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h99, 64'h77};

    // reset state
    do_reset();
    check_all_zero("reset");
    check("reset.stall", {63'h0, stall}, 64'h0);

    // vector table: stall before the edge, registered outputs after it
    for (int i = 0; i < 13; i++) begin
      if_req = tv[i].ir; if_addr = tv[i].ia; d_req = tv[i].dr; d_we = tv[i].dw;
      d_addr = tv[i].da; d_wdata = tv[i].dwd; mem_ack = tv[i].ack; mem_rdata = tv[i].rd;
      #2;
      check($sformatf("tv%0d.stall", i), {63'h0, stall}, {63'h0, tv[i].e_stall});
      step();
      check($sformatf("tv%0d.mem_req", i), {63'h0, mem_req}, {63'h0, tv[i].e_req});
      check($sformatf("tv%0d.done", i), {62'h0, if_done, d_done}, {62'h0, tv[i].e_ifd, tv[i].e_dd});
      check($sformatf("tv%0d.if_rdata", i), if_rdata, tv[i].e_ifr);
      check($sformatf("tv%0d.d_rdata", i), d_rdata, tv[i].e_dr);
      if (tv[i].e_req) begin
        check($sformatf("tv%0d.mem_we", i), {63'h0, mem_we}, {63'h0, tv[i].e_we});
        check($sformatf("tv%0d.mem_addr", i), mem_addr, tv[i].e_addr);
        check($sformatf("tv%0d.mem_wdata", i), mem_wdata, tv[i].e_wdata);
      end
    end

    // starvation: both requesters held continuously, memory acks immediately
    do_reset();
    if_req = 1'b1; if_addr = 64'h1000; d_req = 1'b1; d_addr = 64'h2000;
    stall_low = 0; prev_req = 1'b0;
    for (int cyc = 0; cyc < 200 && grants.size() < 10; cyc++) begin
      #2;
      if (!stall) stall_low++;
      step();
      if (mem_req && !prev_req) grants.push_back((mem_addr == 64'h1000) ? 1 : 2);
      prev_req  = mem_req;
      mem_ack   = mem_req;
      mem_rdata = 64'h1111_0000 + 64'(cyc);
    end
    check("starve.grant_count", 64'(grants.size()), 64'd10);
    for (int i = 0; i < grants.size(); i++)
      check($sformatf("starve.grant%0d", i), 64'(grants[i]), 64'(exp_order[i]));
    check("starve.stall_low_cycles", 64'(stall_low), 64'd0);

    // reset in the middle of a store with mem_ack withheld
    if_req = 1'b0; d_req = 1'b0;
    step();
    mem_ack = 1'b0;
    step(); step();
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'h3000; d_wdata = 64'h55;
    step();
    check("rstmid.granted", {63'h0, mem_req}, 64'h1);
    step(); step();
    #2;
    reset = 1'b1;
    d_req = 1'b0;
    #1;
    check_all_zero("rstmid");
    @(posedge clk);
    #1;
    reset = 1'b0;
    mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rstmid.after%0d", i), {62'h0, d_done, mem_req}, 64'h0);
    end
    mem_ack = 1'b0;

    // timeout: one normal load for nonzero d_rdata, then a load that never gets mem_ack
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h4000;
    step();
    mem_ack = 1'b1; mem_rdata = 64'hABCD;
    step();
    mem_ack = 1'b0; d_req = 1'b0;
    check("tmo.first_load", d_rdata, 64'hABCD);
    step();
    d_req = 1'b1; d_addr = 64'h4100;
    step();
    hi = 0;
    for (int c = 0; c < 40 && mem_req; c++) begin
      hi++;
      step();
    end
`ifdef ARB_TIMEOUT_EN
    check("tmo.busy_cycles", 64'(hi), 64'(TMO));
    check("tmo.done", {63'h0, d_done}, 64'h1);
    check("tmo.rdata", d_rdata, 64'h0);
    check("tmo.err", {63'h0, err}, 64'h1);
    d_req = 1'b0;
    step(); step();
    check("tmo.err_sticky", {63'h0, err}, 64'h1);
    do_reset();
    check("tmo.err_reset", {63'h0, err}, 64'h0);
`else
    check("tmo.busy_cycles", 64'(hi), 64'd40);
    check("tmo.err", {63'h0, err}, 64'h0);
    mem_ack = 1'b1; mem_rdata = 64'h5A;
    step();
    check("tmo.late_done", {63'h0, d_done}, 64'h1);
    check("tmo.late_rdata", d_rdata, 64'h5A);
    d_req = 1'b0; mem_ack = 1'b0;
    step();
`endif

    // randomized run against the transaction-level model
    do_reset();
    owner = 0; losses = 0; wait_cnt = 0;
    m_req = 1'b0; m_we = 1'b0; m_ifd = 1'b0; m_dd = 1'b0;
    m_addr = 64'h0; m_wdata = 64'h0; m_ifr = 64'h0; m_dr = 64'h0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      step();
      // model: an ack finishes the owner's transaction, a free port grants on the next edge
      m_ifd = 1'b0; m_dd = 1'b0;
      if (owner != 0) begin
        if (mem_ack) begin
          if (owner == 1) begin m_ifd = 1'b1; m_ifr = mem_rdata; end
          else begin m_dd = 1'b1; m_dr = mem_rdata; end
          owner = 0; m_req = 1'b0;
        end
      end else if (if_req || d_req) begin
        pick_if = if_req && (!d_req || losses >= 4);
        if (pick_if) begin
          owner = 1; losses = 0; m_addr = if_addr; m_we = 1'b0; m_wdata = 64'h0;
        end else begin
          owner = 2; m_addr = d_addr; m_we = d_we; m_wdata = d_wdata;
          if (if_req) losses++;
        end
        m_req = 1'b1;
      end
      check("rnd.ctl", {59'h0, mem_req, if_done, d_done, err, 1'b0},
                       {59'h0, m_req, m_ifd, m_dd, 1'b0, 1'b0});
      check("rnd.if_rdata", if_rdata, m_ifr);
      check("rnd.d_rdata", d_rdata, m_dr);
      if (m_req) begin
        check("rnd.mem_addr", mem_addr, m_addr);
        check("rnd.mem_wdata_we", mem_wdata ^ {63'h0, mem_we}, m_wdata ^ {63'h0, m_we});
      end
      // requesters: drop or re-request after done, otherwise occasionally start a request
      if (m_ifd) begin
        if ($urandom_range(0, 1) == 0) if_req = 1'b0;
        else if_addr = rnd64();
      end else if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1'b1; if_addr = rnd64();
      end
      if (m_dd) begin
        if ($urandom_range(0, 1) == 0) d_req = 1'b0;
        else begin d_we = 1'($urandom_range(0, 1)); d_addr = rnd64(); d_wdata = rnd64(); end
      end else if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_addr = rnd64(); d_wdata = rnd64();
      end
      // memory: ack within four busy cycles, stray acks while idle
      if (m_req) begin
        wait_cnt++;
        mem_ack = (wait_cnt >= 4) || ($urandom_range(0, 2) == 0);
      end else begin
        wait_cnt = 0;
        mem_ack = ($urandom_range(0, 3) == 0);
      end
      mem_rdata = rnd64();
      #2;
      stall_exp = (if_req && !m_ifd) || (d_req && !m_dd);
      check("rnd.stall", {63'h0, stall}, {63'h0, stall_exp});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
